// File: rtl/cosim_tohost_arbiter.sv
// Round-robin arbiter that merges NUM_CLIENTS valid/ready streams into one tagged to-host endpoint word.
// Optional per-client transfer counters on client_count when COSIM_ARB_STATS_EN is defined.
module cosim_tohost_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_WIDTH  = 24,
  parameter int OUT_WIDTH   = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CLIENTS-1:0]            client_valid,
  output logic [NUM_CLIENTS-1:0]            client_ready,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_data,
  output logic [OUT_WIDTH-1:0]              DataIn,
  output logic                              DataInValid,
  input  logic                              DataInReady
`ifdef COSIM_ARB_STATS_EN
  ,
  output logic [NUM_CLIENTS*16-1:0]         client_count
`endif
);

  localparam int ID_W = (NUM_CLIENTS > 2) ? $clog2(NUM_CLIENTS) : 1;

  if (NUM_CLIENTS < 2 || NUM_CLIENTS > 16) begin : g_bad_clients
    $error("cosim_tohost_arbiter: NUM_CLIENTS must be 2..16");
  end
  if (DATA_WIDTH + ID_W > OUT_WIDTH) begin : g_bad_width
    $error("cosim_tohost_arbiter: DATA_WIDTH + ID_W exceeds OUT_WIDTH");
  end

  logic [OUT_WIDTH-1:0]  data_in_q, data_in_d;
  logic                  data_in_valid_q, data_in_valid_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;

  logic                  load_en;
  logic                  any_valid;
  logic [ID_W-1:0]       winner;
  logic [ID_W:0]         pos;
  logic [DATA_WIDTH-1:0] win_data;

  assign DataIn      = data_in_q;
  assign DataInValid = data_in_valid_q;

  // Gating with rst_n keeps clients from seeing a handshake while the stage is being cleared.
  assign load_en = rst_n && (!data_in_valid_q || DataInReady);

  // Scan offsets from the highest down so the closest valid client to ptr wins last.
  always_comb begin
    winner    = ptr_q;
    any_valid = 1'b0;
    pos       = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_q} + (ID_W + 1)'(k);
      if (pos >= (ID_W + 1)'(NUM_CLIENTS)) begin
        pos = pos - (ID_W + 1)'(NUM_CLIENTS);
      end
      if (client_valid[pos[ID_W-1:0]]) begin
        winner    = pos[ID_W-1:0];
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (winner == ID_W'(i)) begin
        win_data = client_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    client_ready = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      client_ready[i] = load_en && (winner == ID_W'(i)) && client_valid[i];
    end
  end

  always_comb begin
    data_in_d       = data_in_q;
    data_in_valid_d = data_in_valid_q;
    ptr_d           = ptr_q;
    if (load_en) begin
      if (any_valid) begin
        data_in_d                        = '0;
        data_in_d[DATA_WIDTH-1:0]        = win_data;
        data_in_d[DATA_WIDTH +: ID_W]    = winner;
        data_in_valid_d                  = 1'b1;
        ptr_d = (winner == ID_W'(NUM_CLIENTS - 1)) ? '0 : winner + ID_W'(1);
      end else begin
        data_in_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_in_q       <= '0;
      data_in_valid_q <= 1'b0;
      ptr_q           <= '0;
    end else begin
      data_in_q       <= data_in_d;
      data_in_valid_q <= data_in_valid_d;
      ptr_q           <= ptr_d;
    end
  end

`ifdef COSIM_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_CLIENTS];
  logic [15:0] cnt_d [NUM_CLIENTS];

  // Counters saturate so a long-running stream never wraps back to a misleading small value.
  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (client_ready[i] && (cnt_q[i] != 16'hFFFF)) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    client_count = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      client_count[i*16 +: 16] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_cosim_tohost_arbiter.sv
// Directed bench for cosim_tohost_arbiter: scoreboard of expected endpoint words plus a 3-client wrap instance.
module tb_cosim_tohost_arbiter;
  localparam int N  = 4;
  localparam int DW = 24;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  cv, cr;
  logic [N*DW-1:0] cd;
  logic [OW-1:0] din;
  logic          dv, drdy;

  logic [2:0]    cv3, cr3;
  logic [3*DW-1:0] cd3;
  logic [OW-1:0] din3;
  logic          dv3;
  logic          drdy3;

`ifdef COSIM_ARB_STATS_EN
  logic [N*16-1:0] cc;
  logic [3*16-1:0] cc3;
`endif

  int checks = 0;
  int fails  = 0;
  logic [OW-1:0] sb_q[$];

  cosim_tohost_arbiter #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .OUT_WIDTH(OW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .client_valid(cv), .client_ready(cr), .client_data(cd),
    .DataIn(din), .DataInValid(dv), .DataInReady(drdy)
`ifdef COSIM_ARB_STATS_EN
    , .client_count(cc)
`endif
  );

  cosim_tohost_arbiter #(.NUM_CLIENTS(3), .DATA_WIDTH(DW), .OUT_WIDTH(OW)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .client_valid(cv3), .client_ready(cr3), .client_data(cd3),
    .DataIn(din3), .DataInValid(dv3), .DataInReady(drdy3)
`ifdef COSIM_ARB_STATS_EN
    , .client_count(cc3)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] word(input int id);
    logic [1:0] idb;
    idb = 2'(id);
    return {6'b0, idb, cd[id*DW +: DW]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) tick();
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  // Every accepted endpoint beat must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && dv && drdy) begin
      if (sb_q.size() == 0) check("sb_unexpected_beat", 32'(sb_q.size()), 32'd1);
      else check("sb_data", din, sb_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0;
    cv    = '1;
    cd    = {24'hDD3333, 24'hCC2222, 24'hBB1111, 24'hAA0000};
    drdy  = 1'b1;
    cv3   = '0;
    cd3   = {24'h333003, 24'h222002, 24'h111001};
    drdy3 = 1'b1;
    #2;
    check("rst_valid", 32'(dv), 32'd0);
    check("rst_data", din, 32'd0);
    check("rst_ready", 32'(cr), 32'd0);
    tick();
    tick();

    // Round robin from ptr=0 after reset
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sb_q.push_back(word(k % 4));
      @(negedge clk);
      check("rr_ready", 32'(cr), 32'(1) << (k % 4));
      if (k > 0) check("rr_nobubble", 32'(dv), 32'd1);
      tick();
    end
    cv = '0;
    drain();

    // Single client 2
    cd[2*DW +: DW] = 24'hABCDEF;
    cv = 4'b0100;
    sb_q.push_back(32'h02ABCDEF);
    @(negedge clk);
    check("single_ready", 32'(cr), 32'h4);
    tick();
    cv = '0;
    @(negedge clk);
    check("single_valid", 32'(dv), 32'd1);
    tick();
    @(negedge clk);
    check("single_one_beat", 32'(dv), 32'd0);
    tick();

    // Sparse: ptr=3, clients 1 and 3 valid -> 3 then 1
    cv = 4'b1010;
    sb_q.push_back(word(3));
    @(negedge clk);
    check("sparse_ready3", 32'(cr), 32'h8);
    tick();
    sb_q.push_back(word(1));
    @(negedge clk);
    check("sparse_ready1", 32'(cr), 32'h2);
    tick();
    cv = '0;
    drain();

    // Backpressure: ptr=2
    drdy = 1'b0;
    cv = '1;
    sb_q.push_back(word(2));
    @(negedge clk);
    check("bp_grant", 32'(cr), 32'h4);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready", 32'(cr), 32'd0);
      check("bp_data", din, word(2));
      check("bp_valid", 32'(dv), 32'd1);
      tick();
    end
    drdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back(word((k + 3) % 4));
      @(negedge clk);
      check("bp_resume_ready", 32'(cr), 32'(1) << ((k + 3) % 4));
      tick();
    end
    cv = '0;
    drain();

    // Reset while a stalled word is held
    drdy = 1'b0;
    cv = '1;
    tick();
    check("mr_pre_valid", 32'(dv), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(dv), 32'd0);
    check("mr_data", din, 32'd0);
    check("mr_ready", 32'(cr), 32'd0);
    tick();
    rst_n = 1'b1;
    drdy = 1'b1;
    sb_q.push_back(word(0));
    @(negedge clk);
    check("mr_first_grant", 32'(cr), 32'h1);
    tick();
    cv = '0;
    drain();

    // Three-client wrap 2 -> 0
    cv3 = '1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("n3_ready", 32'(cr3), 32'(1) << (k % 3));
      tick();
    end
    cv3 = '0;
    @(negedge clk);
    check("n3_valid", 32'(dv3), 32'd1);
    check("n3_wrap_word", din3, 32'h00111001);
    tick();

`ifdef COSIM_ARB_STATS_EN
    check("stats_after_reset", 32'(cc[15:0]), 32'd1);
    check("stats_n3_c0", 32'(cc3[15:0]), 32'd2);
    cv = 4'b0001;
    for (int k = 0; k < 70000; k++) begin
      sb_q.push_back(word(0));
      tick();
    end
    cv = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      sb_q.push_back(word(1));
      tick();
    end
    cv = '0;
    drain();
    check("stats_c0_sat", 32'(cc[15:0]), 32'h0000FFFF);
    check("stats_c1", 32'(cc[31:16]), 32'd5);
    check("stats_c2", 32'(cc[47:32]), 32'd0);
    check("stats_c3", 32'(cc[63:48]), 32'd0);
`endif

    check("sb_empty_end", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
